// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [3:0] OP_LDR  = 4'b1010;
  localparam logic [3:0] OP_STR  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// ARM-style condition-code evaluator; flags are ordered {N,Z,C,V}.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving external
// instruction memory, data memory, register bank and ALU.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IADDR_W  = 8,
  parameter int unsigned DADDR_W  = 16,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PROG_LEN = 2 ** IADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_en,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               dmem_en,
  output logic               dmem_rw,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [3:0]         rf_dest,
  output logic [3:0]         rf_src1,
  output logic [3:0]         rf_src2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic               rf_we,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [3:0]         alu_opcode,
  output logic               alu_s,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [3:0]         alu_flags,
  output logic [IADDR_W-1:0] pc,
  output logic [3:0]         flags,
  output logic [15:0]        retired,
  output logic               busy,
  output logic               halted
);

  localparam logic [3:0]         LatLast = 4'(MEM_LAT - 1);
  localparam logic [IADDR_W-1:0] PcLast  = IADDR_W'(PROG_LEN - 1);

  state_e              state_q, state_d;
  logic [IADDR_W-1:0]  pc_q, pc_d;
  logic [3:0]          flags_q, flags_d;
  logic [15:0]         retired_q, retired_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   ld_q, ld_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [3:0] opcode;
  logic       cond_pass;
  logic       is_ldr, is_str;
  logic       pc_at_last;
  logic       lat_done;

  assign opcode     = ir_q[27:24];
  assign is_ldr     = (opcode == OP_LDR);
  assign is_str     = (opcode == OP_STR);
  assign pc_at_last = (pc_q == PcLast);
  assign lat_done   = (cnt_q == LatLast);

  cond_eval u_cond_eval (
    .cond  (ir_q[31:28]),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  // Unused inputs/bits kept visible to lint as deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{rf_rdata1, ir_q[10:0]};

  assign rf_dest    = ir_q[22:19];
  assign rf_src2    = ir_q[18:15];
  assign rf_src1    = ir_q[14:11];
  assign alu_opcode = ir_q[27:24];
  assign alu_s      = ir_q[23];
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign retired    = retired_q;
  assign busy       = (state_q != StIdle) && (state_q != StHalt);
  assign halted     = (state_q == StHalt);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    retired_d  = retired_q;
    ir_d       = ir_q;
    res_d      = res_q;
    ld_d       = ld_q;
    cnt_d      = cnt_q;
    imem_en    = 1'b0;
    imem_addr  = '0;
    dmem_en    = 1'b0;
    dmem_rw    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    rf_we      = 1'b0;
    rf_wdata   = '0;

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d   = StFetch;
          pc_d      = '0;
          flags_d   = '0;
          retired_d = '0;
          cnt_d     = '0;
        end
      end
      StFetch: begin
        imem_en   = 1'b1;
        imem_addr = pc_q;
        if (lat_done) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = StDecode;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecode: begin
        if (!cond_pass) begin
          if (pc_at_last) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end else if (opcode == OP_HALT) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        res_d = alu_result;
        if (ir_q[23]) begin
          flags_d = alu_flags;
        end
        state_d = (is_ldr || is_str) ? StMem : StWb;
      end
      StMem: begin
        dmem_en   = 1'b1;
        dmem_rw   = is_ldr;
        dmem_addr = res_q[DADDR_W-1:0];
        if (is_str) begin
          dmem_wdata = rf_rdata2;
        end
        if (lat_done) begin
          if (is_ldr) begin
            ld_d = dmem_rdata;
          end
          cnt_d   = '0;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWb: begin
        rf_we    = !is_str;
        rf_wdata = is_ldr ? ld_q : res_q;
        if (retired_q != 16'hFFFF) begin
          retired_d = retired_q + 16'd1;
        end
        if (pc_at_last) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      flags_q   <= '0;
      retired_q <= '0;
      ir_q      <= '0;
      res_q     <= '0;
      ld_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      ld_q      <= ld_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs, expected register and
// data-memory traffic queued by the stimulus and checked by a separate monitor.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_en;
  logic        dmem_rw;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [3:0]  rf_dest, rf_src1, rf_src2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [3:0]  alu_opcode;
  logic        alu_s;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [7:0]  pc;
  logic [3:0]  flags;
  logic [15:0] retired;
  logic        busy;
  logic        halted;

  cpu_sequencer #(
    .DATA_W   (32),
    .IADDR_W  (8),
    .DADDR_W  (16),
    .MEM_LAT  (3),
    .PROG_LEN (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_en    (dmem_en),
    .dmem_rw    (dmem_rw),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .rf_dest    (rf_dest),
    .rf_src1    (rf_src1),
    .rf_src2    (rf_src2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .alu_opcode (alu_opcode),
    .alu_s      (alu_s),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .pc         (pc),
    .flags      (flags),
    .retired    (retired),
    .busy       (busy),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory and per-pc ALU responses are directed tables.
  logic [31:0] imem    [4];
  logic [31:0] alu_res [4];
  logic [3:0]  alu_flg [4];

  assign imem_rdata = imem[imem_addr[1:0]];
  assign alu_result = alu_res[pc[1:0]];
  assign alu_flags  = alu_flg[pc[1:0]];
  assign dmem_rdata = 32'h0000_AAA3;
  assign rf_rdata1  = 32'd0;
  assign rf_rdata2  = 32'd14;

  typedef struct packed {
    logic        is_mem;
    logic        rw;
    logic [15:0] addr;
    logic [3:0]  dest;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NV = 4'hF;
  localparam logic [3:0] ADD = 4'h0, LDR = 4'hA, STR = 4'hB, HLT = 4'hF;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                     input logic s, input logic [3:0] d,
                                     input logic [3:0] s2);
    return {c, op, s, d, s2, 15'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic exp_rf(input logic [3:0] d, input logic [31:0] data);
    exp_q.push_back('{1'b0, 1'b0, 16'd0, d, data});
  endtask

  task automatic exp_mem(input logic rw, input logic [15:0] a, input logic [31:0] data,
                         input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, rw, a, 4'd0, data});
  endtask

  task automatic compare_ev(input string nm, input ev_t got);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected: got %h expected none", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, got, e);
      end
    end
  endtask

  // Monitor: every rf write and every data-memory cycle is matched in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rf_we) compare_ev("rf_write", '{1'b0, 1'b0, 16'd0, rf_dest, rf_wdata});
        if (dmem_en)
          compare_ev("dmem_cycle",
                     '{1'b1, dmem_rw, dmem_addr, 4'd0, dmem_rw ? 32'd0 : dmem_wdata});
      end
    end
  end

  task automatic load(input logic [31:0] i0, i1, i2, i3,
                      input logic [31:0] r0, r1, r2, r3,
                      input logic [3:0] f0, f1, f2, f3);
    imem[0] = i0; imem[1] = i1; imem[2] = i2; imem[3] = i3;
    alu_res[0] = r0; alu_res[1] = r1; alu_res[2] = r2; alu_res[3] = r3;
    alu_flg[0] = f0; alu_flg[1] = f1; alu_flg[2] = f2; alu_flg[3] = f3;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    load(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_strobes", {29'd0, imem_en, dmem_en, rf_we}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // ADD r3 S=1; LDR r4 addr 3; STR addr 1 data 14; EQ ADD with Z=0 skipped.
    load(mk(AL, ADD, 1'b1, 4'd3, 4'd0), mk(AL, LDR, 1'b0, 4'd4, 4'd0),
         mk(AL, STR, 1'b0, 4'd0, 4'd5), mk(EQ, ADD, 1'b0, 4'd5, 4'd0),
         32'd5, 32'd3, 32'd1, 32'd99, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    exp_rf(4'd3, 32'd5);
    exp_mem(1'b1, 16'd3, 32'd0, 3);
    exp_rf(4'd4, 32'h0000_AAA3);
    exp_mem(1'b0, 16'd1, 32'd14, 3);
    pulse_start();
    chk("p1_busy", 32'(busy), 32'd1);
    wait_halt("p1");
    chk("p1_pc", 32'(pc), 32'd3);
    chk("p1_retired", 32'(retired), 32'd3);
    chk("p1_flags", 32'(flags), 32'd0);

    // S=1 sets Z; EQ then executes; NV never; S=0 leaves flags alone.
    load(mk(AL, ADD, 1'b1, 4'd1, 4'd0), mk(EQ, ADD, 1'b0, 4'd2, 4'd0),
         mk(NV, ADD, 1'b0, 4'd6, 4'd0), mk(AL, ADD, 1'b0, 4'd7, 4'd0),
         32'd7, 32'd9, 32'h66, 32'h11, 4'b0100, 4'b1111, 4'b0000, 4'b1011);
    exp_rf(4'd1, 32'd7);
    exp_rf(4'd2, 32'd9);
    exp_rf(4'd7, 32'h11);
    pulse_start();
    wait_halt("p2");
    chk("p2_pc", 32'(pc), 32'd3);
    chk("p2_retired", 32'(retired), 32'd3);
    chk("p2_flags", 32'(flags), 32'h4);

    // Four plain ADDs; a second start mid-run must be ignored.
    load(mk(AL, ADD, 1'b0, 4'd8, 4'd0), mk(AL, ADD, 1'b0, 4'd9, 4'd0),
         mk(AL, ADD, 1'b0, 4'd10, 4'd0), mk(AL, ADD, 1'b0, 4'd11, 4'd0),
         32'h21, 32'h22, 32'h23, 32'h24, 4'd0, 4'd0, 4'd0, 4'd0);
    exp_rf(4'd8, 32'h21);
    exp_rf(4'd9, 32'h22);
    exp_rf(4'd10, 32'h23);
    exp_rf(4'd11, 32'h24);
    pulse_start();
    chk("p3_flags_cleared", 32'(flags), 32'd0);
    repeat (4) @(negedge clk);
    pulse_start();
    wait_halt("p3");
    chk("p3_pc", 32'(pc), 32'd3);
    chk("p3_retired", 32'(retired), 32'd4);

    // HALT opcode stops without advancing pc.
    load(mk(AL, ADD, 1'b0, 4'd12, 4'd0), mk(AL, HLT, 1'b0, 4'd0, 4'd0),
         mk(AL, ADD, 1'b0, 4'd13, 4'd0), mk(AL, ADD, 1'b0, 4'd14, 4'd0),
         32'h30, 32'd0, 32'h31, 32'h32, 4'd0, 4'd0, 4'd0, 4'd0);
    exp_rf(4'd12, 32'h30);
    pulse_start();
    wait_halt("p4");
    chk("p4_pc", 32'(pc), 32'd1);
    chk("p4_retired", 32'(retired), 32'd1);

    // Reset during the first STR memory cycle aborts the instruction.
    load(mk(AL, STR, 1'b0, 4'd0, 4'd5), mk(AL, ADD, 1'b0, 4'd1, 4'd0),
         mk(AL, ADD, 1'b0, 4'd2, 4'd0), mk(AL, ADD, 1'b0, 4'd3, 4'd0),
         32'd2, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    exp_mem(1'b0, 16'd2, 32'd14, 1);
    pulse_start();
    n = 0;
    while (!dmem_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("p5_reached_mem", 32'(dmem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("p5_rst_dmem_en", 32'(dmem_en), 32'd0);
    chk("p5_rst_outputs", {26'd0, busy, halted, rf_we, imem_en, dmem_rw, dmem_en}, 32'd0);
    chk("p5_rst_pc", 32'(pc), 32'd0);
    chk("p5_rst_wdata", dmem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("p5_idle_busy", 32'(busy), 32'd0);
    chk("p5_idle_halted", 32'(halted), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: instruction, register and data-memory word width.
REQ-002 Parameter IADDR_W, default 8: program-counter and instruction-memory address width.
REQ-003 Parameter DADDR_W, default 16: data-memory address width.
REQ-004 Parameter MEM_LAT, default 1 (range 1..15): cycles an enable is held before memory read data is sampled.
REQ-005 Parameter PROG_LEN, default 2**IADDR_W: number of instruction words in the program.
REQ-006 Clk  in  1: single clock; all state changes on the rising edge.
REQ-007 Reset  in  1: asynchronous, active-low reset.
REQ-008 start  in  1: one-cycle pulse that begins execution at pc 0.
REQ-009 imem_en / imem_addr / imem_rdata  out 1 / out IADDR_W / in DATA_W: instruction-memory read port.
REQ-010 dmem_en / dmem_rw / dmem_addr / dmem_wdata / dmem_rdata  out 1 / out 1 / out DADDR_W / out DATA_W / in DATA_W: data-memory port, dmem_rw 1 = read, 0 = write.
REQ-011 rf_dest / rf_src1 / rf_src2  out 4 each: register-bank selects, taken from ir[22:19], ir[14:11] and ir[18:15].
REQ-012 rf_rdata1 / rf_rdata2  in DATA_W: register-bank read data.
REQ-013 rf_we / rf_wdata  out 1 / out DATA_W: register write strobe and write data.
REQ-014 alu_opcode / alu_s  out 4 / out 1: ir[27:24] and ir[23].
REQ-015 alu_result / alu_flags  in DATA_W / in 4: ALU result and new flags, flags ordered {N,Z,C,V}.
REQ-016 pc / flags / retired / busy / halted  out IADDR_W / 4 / 16 / 1 / 1: program counter, flag register, retired-instruction count and status bits.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 IDLE SHALL go to FETCH on start, clearing pc, flags and retired to 0.
REQ-019 FETCH SHALL assert imem_en with imem_addr=pc for exactly MEM_LAT cycles, load ir from imem_rdata on the last of those cycles, and then go to DECODE.
REQ-020 DECODE (1 cycle) SHALL evaluate ir[31:28] against flags using the ARM condition table (0000 EQ through 1101 LE, 1110 AL, 1111 NV = never).
REQ-021 If the condition fails, DECODE SHALL advance pc, leave retired unchanged and go to FETCH, or to HALT per REQ-028.
REQ-022 If the opcode is OP_HALT, DECODE SHALL go to HALT without advancing pc.
REQ-023 EXEC (1 cycle) SHALL latch alu_result into res and, when S=1, load flags from alu_flags; flags SHALL be unchanged when S=0.
REQ-024 After EXEC the FSM SHALL go to MEM for OP_LDR and OP_STR, and to WB for all other opcodes.
REQ-025 MEM SHALL hold dmem_en=1 with dmem_addr=res[DADDR_W-1:0] for MEM_LAT cycles.
- OP_LDR: dmem_rw=1; dmem_rdata is latched on the last cycle.
- OP_STR: dmem_rw=0 and dmem_wdata=rf_rdata2, held stable for every MEM_LAT cycle.
REQ-026 WB (1 cycle) SHALL increment retired (saturating at 16'hFFFF) and advance pc.
- rf_we is asserted for all opcodes except OP_STR.
- rf_wdata is the loaded word for OP_LDR and res otherwise.
REQ-027 rf_we, imem_en and dmem_en SHALL be 0 in every state and cycle not named in REQ-019, REQ-025 and REQ-026.
REQ-028 Advancing pc from PROG_LEN-1 SHALL go to HALT with pc held; otherwise pc SHALL increment by 1 and wrap modulo 2**IADDR_W.
REQ-029 In HALT, halted SHALL be 1; a start pulse SHALL return the FSM to IDLE-entry behaviour per REQ-018.
REQ-030 busy SHALL be 1 in every state except IDLE and HALT; start SHALL be ignored while busy=1.
REQ-031 Latency: an ALU instruction with MEM_LAT=1 SHALL retire 4 cycles after FETCH entry, and LDR/STR SHALL retire in 5 cycles.

Reset
REQ-032 While Reset=0, state SHALL be IDLE and pc, flags, retired, ir, res, busy, halted and all strobes SHALL be 0.
REQ-033 Reset asserted mid-instruction SHALL abort that instruction with no rf_we or dmem write issued afterwards.

Structure
REQ-034 Package cpu_pkg SHALL hold OP_LDR=4'b1010, OP_STR=4'b1011, OP_HALT=4'b1111, the condition-code constants and the state enumeration.
REQ-035 Condition evaluation SHALL be a combinational sub-module, cond_eval (inputs cond and flags; output pass).

Verification
REQ-036 ALU ADD r3 (AL, S=1), alu_result=5, alu_flags=0000 -> one rf_we pulse to r3 with data 5, flags=0000, retired=1.
REQ-037 LDR with res=3 and dmem_rdata=32'hAAA3, MEM_LAT=3 -> dmem_en high 3 cycles with rw=1 and addr 3, then rf_wdata=32'hAAA3.
REQ-038 STR with rf_rdata2=14 and res=1 -> dmem_rw=0, addr 1, wdata 14, no rf_we.
REQ-039 EQ instruction with Z=0 -> no rf_we, pc+1, retired unchanged; the same instruction with Z=1 executes.
REQ-040 PROG_LEN=4 with no HALT opcode -> halted=1 after pc 3 retires, pc=3, retired=4; a later start restarts at pc 0.
REQ-041 Reset=0 during MEM of an STR -> dmem_en drops immediately, all outputs 0, state IDLE.
